// File: rtl/word_fetch_if.sv
// Bus bundle for word_fetch: request/flush handshake, assembled word result
// and the byte-wide read port toward the RAM.
interface word_fetch_if #(
  parameter int ADDR_W = 17
);
  logic              req_in;
  logic [ADDR_W-1:0] addr_in;
  logic              flush_in;
  logic              busy_out;
  logic              valid_out;
  logic [31:0]       data_out;
  logic              ram_en_out;
  logic              ram_r_nw_out;
  logic [ADDR_W-1:0] ram_a_out;
  logic [7:0]        ram_d_in;

  modport slave (
    input  req_in, addr_in, flush_in, ram_d_in,
    output busy_out, valid_out, data_out, ram_en_out, ram_r_nw_out, ram_a_out
  );

  modport master (
    output req_in, addr_in, flush_in, ram_d_in,
    input  busy_out, valid_out, data_out, ram_en_out, ram_r_nw_out, ram_a_out
  );
endinterface

// File: rtl/word_fetch.sv
// Fetches one little-endian 32-bit word as four byte reads from a RAM with a
// one-cycle read latency; result appears six cycles after the accept cycle.
module word_fetch #(
  parameter int ADDR_W = 17
) (
  input  logic        clk_in,
  input  logic        rstn_in,
  word_fetch_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    RD3  = 3'd4,
    WAIT = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] base_r, base_s;
  logic [ADDR_W-1:0] ram_a_r, ram_a_s;
  logic              en_r, en_s;
  logic [31:0]       asm_r, asm_s;
  logic [31:0]       data_r, data_s;
  logic              valid_r, valid_s;
  logic              busy_r, busy_s;

  // Next-state and next-output computation; flush aborts any fetch in flight.
  always_comb begin
    state_s = state_r;
    base_s  = base_r;
    ram_a_s = ram_a_r;
    en_s    = 1'b0;
    asm_s   = asm_r;
    data_s  = data_r;
    valid_s = 1'b0;
    if ((state_r != IDLE) && bus.flush_in) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_in && !bus.flush_in) begin
            state_s = RD0;
            base_s  = bus.addr_in;
            ram_a_s = bus.addr_in;
            en_s    = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        RD0: begin
          state_s = RD1;
          ram_a_s = base_r + ADDR_W'(2'd1);
          en_s    = 1'b1;
        end
        // Bytes arrive one cycle behind their address and shift in from the top.
        RD1: begin
          state_s = RD2;
          ram_a_s = base_r + ADDR_W'(2'd2);
          en_s    = 1'b1;
          asm_s   = {bus.ram_d_in, asm_r[31:8]};
        end
        RD2: begin
          state_s = RD3;
          ram_a_s = base_r + ADDR_W'(2'd3);
          en_s    = 1'b1;
          asm_s   = {bus.ram_d_in, asm_r[31:8]};
        end
        RD3: begin
          state_s = WAIT;
          asm_s   = {bus.ram_d_in, asm_r[31:8]};
        end
        WAIT: begin
          state_s = IDLE;
          asm_s   = {bus.ram_d_in, asm_r[31:8]};
          data_s  = {bus.ram_d_in, asm_r[31:8]};
          valid_s = 1'b1;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
    busy_s = (state_s != IDLE);
  end

  // State register.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      base_r  <= '0;
      ram_a_r <= '0;
      en_r    <= 1'b0;
      asm_r   <= 32'd0;
      data_r  <= 32'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      base_r  <= base_s;
      ram_a_r <= ram_a_s;
      en_r    <= en_s;
      asm_r   <= asm_s;
      data_r  <= data_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
    end
  end

  assign bus.busy_out     = busy_r;
  assign bus.valid_out    = valid_r;
  assign bus.data_out     = data_r;
  assign bus.ram_en_out   = en_r;
  assign bus.ram_a_out    = ram_a_r;
  assign bus.ram_r_nw_out = 1'b1;

endmodule

// File: tb/tb_word_fetch.sv
// Directed and randomized fetches of word_fetch against a byte-array RAM model
// and a cycle-by-cycle expectation derived from the fetch timing rules.
module tb_word_fetch;
  localparam int AW    = 17;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rstn;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_word;
  logic [7:0]  mem [DEPTH];

  word_fetch_if #(.ADDR_W(AW)) bus ();
  word_fetch #(.ADDR_W(AW)) dut (.clk_in(clk), .rstn_in(rstn), .bus(bus));

  always #5 clk = ~clk;

  // RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.ram_en_out) bus.ram_d_in <= mem[bus.ram_a_out];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int a);
    return {mem[(a + 3) % DEPTH], mem[(a + 2) % DEPTH], mem[(a + 1) % DEPTH], mem[a % DEPTH]};
  endfunction

  // Called at a negedge in an accept-capable cycle T; returns at negedge of T+6.
  // noise: 0 none, 1 directed competing request at T+3, 2 random requests while busy.
  task automatic fetch(input logic [AW-1:0] a, input int noise);
    int          ai;
    int          off;
    logic [31:0] w;
    ai = int'(a);
    w  = model_word(ai);
    bus.req_in   = 1'b1;
    bus.addr_in  = a;
    bus.flush_in = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus.req_in = 1'b0;
      if (noise == 1 && k == 3) begin
        bus.req_in  = 1'b1;
        bus.addr_in = 17'h00040;
      end else if (noise == 2 && k < 6) begin
        bus.req_in  = 1'($urandom_range(0, 1));
        bus.addr_in = AW'($urandom_range(0, DEPTH - 1));
      end
      off = (k < 4) ? k - 1 : 3;
      chk("busy", {31'd0, bus.busy_out}, {31'd0, (k <= 5)});
      chk("valid", {31'd0, bus.valid_out}, {31'd0, (k == 6)});
      chk("ram_en", {31'd0, bus.ram_en_out}, {31'd0, (k <= 4)});
      chk("ram_a", {15'd0, bus.ram_a_out}, 32'((ai + off) % DEPTH));
      chk("data", bus.data_out, (k == 6) ? w : last_word);
    end
    bus.req_in = 1'b0;
    last_word  = w;
  endtask

  initial begin
    int          fa;
    logic [AW-1:0] ra;
    rstn         = 1'b0;
    bus.req_in   = 1'b0;
    bus.flush_in = 1'b0;
    bus.addr_in  = '0;
    last_word    = 32'd0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    mem[16] = 8'h13; mem[17] = 8'h05; mem[18] = 8'h10; mem[19] = 8'h00;

    #3;
    chk("rst_busy", {31'd0, bus.busy_out}, 32'd0);
    chk("rst_valid", {31'd0, bus.valid_out}, 32'd0);
    chk("rst_data", bus.data_out, 32'd0);
    chk("rst_en", {31'd0, bus.ram_en_out}, 32'd0);
    chk("rst_a", {15'd0, bus.ram_a_out}, 32'd0);
    chk("r_nw", {31'd0, bus.ram_r_nw_out}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Known word, then back-to-back fetch with a competing request at T+3.
    fetch(17'h00010, 0);
    chk("word_0x10", last_word, 32'h00100513);
    fetch(17'h00020, 1);
    @(negedge clk);
    chk("no_extra_valid", {31'd0, bus.valid_out}, 32'd0);

    // Flush while in RD2.
    ra = AW'($urandom_range(0, DEPTH - 1));
    fa = int'(ra);
    bus.req_in  = 1'b1;
    bus.addr_in = ra;
    @(negedge clk);
    bus.req_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.flush_in = 1'b1;
    @(negedge clk);
    bus.flush_in = 1'b0;
    chk("flush_busy", {31'd0, bus.busy_out}, 32'd0);
    chk("flush_en", {31'd0, bus.ram_en_out}, 32'd0);
    chk("flush_a_hold", {15'd0, bus.ram_a_out}, 32'((fa + 2) % DEPTH));
    chk("flush_data", bus.data_out, last_word);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flush_no_valid", {31'd0, bus.valid_out}, 32'd0);
      chk("flush_idle", {31'd0, bus.busy_out}, 32'd0);
    end

    // Flush beats a simultaneous request in IDLE.
    bus.req_in   = 1'b1;
    bus.flush_in = 1'b1;
    bus.addr_in  = 17'h00100;
    @(negedge clk);
    bus.req_in   = 1'b0;
    bus.flush_in = 1'b0;
    chk("prio_busy", {31'd0, bus.busy_out}, 32'd0);
    chk("prio_en", {31'd0, bus.ram_en_out}, 32'd0);

    // Address wrap, then random back-to-back fetches with noise while busy.
    fetch(17'h1FFFE, 0);
    for (int i = 0; i < 8; i++) fetch(AW'($urandom_range(0, DEPTH - 1)), 2);

    // Reset mid-cycle during a fetch.
    bus.req_in  = 1'b1;
    bus.addr_in = AW'($urandom_range(0, DEPTH - 1));
    @(negedge clk);
    bus.req_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", {31'd0, bus.busy_out}, 32'd0);
    chk("arst_valid", {31'd0, bus.valid_out}, 32'd0);
    chk("arst_data", bus.data_out, 32'd0);
    chk("arst_en", {31'd0, bus.ram_en_out}, 32'd0);
    chk("arst_a", {15'd0, bus.ram_a_out}, 32'd0);
    @(negedge clk);
    chk("arst_hold_valid", {31'd0, bus.valid_out}, 32'd0);
    rstn      = 1'b1;
    last_word = 32'd0;
    fetch(AW'($urandom_range(0, DEPTH - 1)), 2);
    @(negedge clk);
    chk("end_no_valid", {31'd0, bus.valid_out}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/word_fetch.md
WORD_FETCH -- requirements
Module: word_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, RAM byte-address width.
REQ-002 SHALL have port clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rstn_in  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_in  input  1  word-fetch request; accepted only when busy_out=0.
REQ-005 SHALL have port addr_in  input  ADDR_W  byte address of the word's lowest byte; sampled on accept.
REQ-006 SHALL have port flush_in  input  1  abort the current fetch.
REQ-007 SHALL have port busy_out  output  1  fetch in progress.
REQ-008 SHALL have port valid_out  output  1  one-cycle pulse: data_out holds a new word.
REQ-009 SHALL have port data_out  output  32  assembled little-endian word.
REQ-010 SHALL have port ram_en_out  output  1  RAM enable.
REQ-011 SHALL have port ram_r_nw_out  output  1  RAM read/not-write.
REQ-012 SHALL have port ram_a_out  output  ADDR_W  RAM byte address.
REQ-013 SHALL have port ram_d_in  input  8  RAM read data; valid one cycle after its address is presented.

Function
REQ-014 SHALL implement the FSM states IDLE, RD0, RD1, RD2, RD3 and WAIT.
REQ-015 SHALL leave IDLE for RD0 when req_in=1 and flush_in=0, latching addr_in as base; this is the accept cycle T.
REQ-016 SHALL step unconditionally RD0->RD1->RD2->RD3->WAIT->IDLE, one state per cycle, unless flushed.
REQ-017 SHALL drive ram_a_out=base+k and ram_en_out=1 in state RDk (cycles T+1..T+4); otherwise ram_en_out=0 and ram_a_out holds its last value.
REQ-018 SHALL compute base+k modulo 2^ADDR_W, so the address wraps from all-ones to zero.
REQ-019 SHALL hold ram_r_nw_out=1 at all times; the block never writes.
REQ-020 SHALL capture ram_d_in as byte k at the end of cycle T+2+k (states RD1, RD2, RD3, WAIT for k=0..3).
REQ-021 SHALL drive data_out={byte3,byte2,byte1,byte0} and valid_out=1 for exactly cycle T+6, the first IDLE cycle after WAIT; total latency is 6 cycles.
REQ-022 SHALL hold data_out stable between valid pulses; in-progress bytes use a separate shift/assembly register.
REQ-023 SHALL drive busy_out=1 in states RD0..WAIT and 0 in IDLE.
REQ-024 SHALL accept a new request in the valid_out cycle, giving back-to-back fetches every 6 cycles.
REQ-025 SHALL ignore req_in while busy_out=1, without queuing it.
REQ-026 SHALL go to IDLE on the next edge when flush_in=1 in any non-IDLE state; ram_en_out=0 from that edge and no valid_out is generated for the aborted fetch.
REQ-027 SHALL give flush_in priority over req_in when both are 1 in IDLE, so no accept occurs.
REQ-028 SHALL leave data_out unchanged on flush.

Reset
REQ-029 SHALL, while rstn_in=0 (asynchronous, independent of clk_in), force state=IDLE, busy_out=0, valid_out=0, data_out=0, ram_en_out=0, ram_a_out=0, assembly register=0, base=0.
REQ-030 SHALL abandon an in-progress fetch on reset mid-operation, with no valid_out after reset release.
REQ-031 SHALL accept a request on the first rising edge after rstn_in deasserts.

Verification
REQ-032 SHALL cover: reset asserted mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
REQ-033 SHALL cover: RAM[0x00010..0x00013]=0x13,0x05,0x10,0x00; req with addr 0x00010 at T -> ram_a_out 0x00010..0x00013 on T+1..T+4; valid_out=1 and data_out=0x00100513 at T+6 only.
REQ-034 SHALL cover: req with addr 0x1FFFE -> ram_a_out sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
REQ-035 SHALL cover: req with addr 0x00020 at T, second req with addr 0x00040 at T+3 -> second ignored; one valid at T+6; ram_a_out never 0x00040.
REQ-036 SHALL cover: flush_in=1 in RD2 -> busy_out=0 and ram_en_out=0 next cycle; no valid_out; data_out retains previous word.
REQ-037 SHALL cover: requests at T and T+6 -> valid pulses at T+6 and T+12 with correct words; rstn_in low at T+3 of a third fetch -> no valid pulse follows.
